// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer for the single-port data memory.
// Port 0 is the CPU load/store path, port 1 the loader/DMA path. A granted
// command is held on the memory interface for LATENCY cycles, then a one-cycle
// done pulse is issued to the owning port. Ties are resolved round-robin.
module dmem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   output logic              gnt0_o,
   output logic              done0_o,
   output logic [DATA_W-1:0] rdata0_o,

   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              gnt1_o,
   output logic              done1_o,
   output logic [DATA_W-1:0] rdata1_o,

   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,

   output logic              busy_o
);

   // Counter holds LATENCY at most, so this width never overflows on load.
   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               owner_q, owner_d;  // port owning the in-flight access
   logic               last_q, last_d;    // last-grant pointer

   logic               sel_valid;
   logic               sel_port;

   logic               gnt0_d, gnt1_d;
   logic               done0_d, done1_d;
   logic               mem_en_d, mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_d;
   logic [DATA_W-1:0]  mem_wdata_d;
   logic [DATA_W-1:0]  rdata0_d, rdata1_d;
   logic               busy_d;

   // Request selection: a lone requester wins; on a tie the port that was
   // not granted last time wins.
   always_comb begin
      sel_valid = req0_i | req1_i;
      if (req0_i && req1_i) begin
         sel_port = ~last_q;
      end else begin
         sel_port = req1_i;
      end
   end

   // Next-state and next-output computation; every output is registered.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      last_d      = last_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      mem_en_d    = mem_en_o;
      mem_we_d    = mem_we_o;
      mem_addr_d  = mem_addr_o;
      mem_wdata_d = mem_wdata_o;
      rdata0_d    = rdata0_o;
      rdata1_d    = rdata1_o;

      unique case (state_q)
         S_IDLE: begin
            if (sel_valid) begin
               state_d  = S_ACCESS;
               cnt_d    = CNT_W'(LATENCY);
               owner_d  = sel_port;
               last_d   = sel_port;
               gnt0_d   = ~sel_port;
               gnt1_d   = sel_port;
               mem_en_d = 1'b1;
               if (sel_port) begin
                  mem_we_d    = we1_i;
                  mem_addr_d  = addr1_i;
                  mem_wdata_d = wdata1_i;
               end else begin
                  mem_we_d    = we0_i;
                  mem_addr_d  = addr0_i;
                  mem_wdata_d = wdata0_i;
               end
            end
         end

         S_ACCESS: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Final access cycle: read data is valid now, finish on this edge.
            if (cnt_q == CNT_W'(1)) begin
               state_d  = S_DONE;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               done0_d  = ~owner_q;
               done1_d  = owner_q;
               if (!mem_we_o) begin
                  if (owner_q) begin
                     rdata1_d = mem_rdata_i;
                  end else begin
                     rdata0_d = mem_rdata_i;
                  end
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         gnt0_o      <= 1'b0;
         gnt1_o      <= 1'b0;
         done0_o     <= 1'b0;
         done1_o     <= 1'b0;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         rdata0_o    <= '0;
         rdata1_o    <= '0;
         busy_o      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         gnt0_o      <= gnt0_d;
         gnt1_o      <= gnt1_d;
         done0_o     <= done0_d;
         done1_o     <= done1_d;
         mem_en_o    <= mem_en_d;
         mem_we_o    <= mem_we_d;
         mem_addr_o  <= mem_addr_d;
         mem_wdata_o <= mem_wdata_d;
         rdata0_o    <= rdata0_d;
         rdata1_o    <= rdata1_d;
         busy_o      <= busy_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model tracks the cycles elapsed
// since the current grant and derives every output from that count; directed
// vectors add hand-computed literal expectations at the key cycles.
module tb_dmem_arbiter;

   localparam int LAT = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;

   logic          clk;
   logic          rst;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, done0, done1;
   logic [DW-1:0] rdata0, rdata1;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          busy;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req0_i      (req0),
      .we0_i       (we0),
      .addr0_i     (addr0),
      .wdata0_i    (wdata0),
      .gnt0_o      (gnt0),
      .done0_o     (done0),
      .rdata0_o    (rdata0),
      .req1_i      (req1),
      .we1_i       (we1),
      .addr1_i     (addr1),
      .wdata1_i    (wdata1),
      .gnt1_o      (gnt1),
      .done1_o     (done1),
      .rdata1_o    (rdata1),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .busy_o      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- transaction-level model ----------------
   // m_phase = 0 when idle, otherwise the number of cycles since the grant
   // edge: 1 is the grant cycle, 1..LAT the access, LAT+1 the done cycle.
   int            m_phase = 0;
   int            m_owner = 0;
   int            m_last  = 1;
   logic          m_we    = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_rdata0 = '0;
   logic [DW-1:0] m_rdata1 = '0;

   function automatic int pick(input logic r0, input logic r1, input int last);
      if (r0 && r1) return 1 - last;
      return r1 ? 1 : 0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase  <= 0;
         m_last   <= 1;
         m_rdata0 <= '0;
         m_rdata1 <= '0;
      end else if (m_phase == 0) begin
         if (req0 || req1) begin
            m_phase <= 1;
            m_owner <= pick(req0, req1, m_last);
            m_last  <= pick(req0, req1, m_last);
            if (pick(req0, req1, m_last) == 1) begin
               m_we <= we1; m_addr <= addr1; m_wdata <= wdata1;
            end else begin
               m_we <= we0; m_addr <= addr0; m_wdata <= wdata0;
            end
         end
      end else if (m_phase == LAT + 1) begin
         m_phase <= 0;
      end else begin
         if (m_phase == LAT && !m_we) begin
            if (m_owner == 1) m_rdata1 <= mem_rdata;
            else              m_rdata0 <= mem_rdata;
         end
         m_phase <= m_phase + 1;
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_model();
      logic en;
      en = (m_phase >= 1) && (m_phase <= LAT);
      check("gnt0",   64'(gnt0),   64'(m_phase == 1 && m_owner == 0));
      check("gnt1",   64'(gnt1),   64'(m_phase == 1 && m_owner == 1));
      check("mem_en", 64'(mem_en), 64'(en));
      check("mem_we", 64'(mem_we), 64'(en && m_we));
      if (en) begin
         check("mem_addr",  64'(mem_addr),  64'(m_addr));
         check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      check("done0",  64'(done0),  64'(m_phase == LAT + 1 && m_owner == 0));
      check("done1",  64'(done1),  64'(m_phase == LAT + 1 && m_owner == 1));
      check("busy",   64'(busy),   64'(m_phase != 0));
      check("rdata0", 64'(rdata0), 64'(m_rdata0));
      check("rdata1", 64'(rdata1), 64'(m_rdata1));
   endtask

   // One clock: sample at the falling edge, compare against the model.
   task automatic cycle();
      @(negedge clk);
      cyc++;
      compare_model();
   endtask

   int g_port[$];
   int g_cyc[$];

   initial begin
      rst = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100; wdata0 = 32'h0;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h200; wdata1 = 32'h0;
      mem_rdata = 32'hAAAA0000;

      // Reset with both requests high: everything quiet.
      cycle();
      check("rst_gnt0",   64'(gnt0),      64'd0);
      check("rst_gnt1",   64'(gnt1),      64'd0);
      check("rst_mem_en", 64'(mem_en),    64'd0);
      check("rst_mem_we", 64'(mem_we),    64'd0);
      check("rst_addr",   64'(mem_addr),  64'd0);
      check("rst_wdata",  64'(mem_wdata), 64'd0);
      check("rst_done",   64'({done0, done1}), 64'd0);
      check("rst_rdata",  64'({rdata0, rdata1}), 64'd0);
      check("rst_busy",   64'(busy),      64'd0);

      // Release: first tie goes to port 0, port 1 served afterwards.
      rst = 1'b0;
      cycle();
      check("tie_first_gnt0", 64'(gnt0), 64'd1);
      check("tie_first_gnt1", 64'(gnt1), 64'd0);
      req0 = 1'b0;
      cycle();
      cycle();
      check("t1_done0",  64'(done0),  64'd1);
      check("t1_rdata0", 64'(rdata0), 64'hAAAA0000);
      cycle();
      cycle();
      check("t1_gnt1", 64'(gnt1), 64'd1);
      req1 = 1'b0;
      cycle(); cycle(); cycle();

      // Port 0 read of 0x10.
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; mem_rdata = 32'hDEADBEEF;
      cycle();
      check("rd_gnt0",   64'(gnt0),     64'd1);
      check("rd_en_c1",  64'(mem_en),   64'd1);
      check("rd_addr",   64'(mem_addr), 64'h10);
      req0 = 1'b0;
      cycle();
      check("rd_en_c2",  64'(mem_en),   64'd1);
      cycle();
      check("rd_done0",  64'(done0),    64'd1);
      check("rd_rdata0", 64'(rdata0),   64'hDEADBEEF);
      check("rd_en_c3",  64'(mem_en),   64'd0);
      cycle();
      check("rd_busy_c4", 64'(busy),    64'd0);

      // Port 1 write; read data on port 1 must be untouched.
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678; mem_rdata = 32'h55555555;
      cycle();
      check("wr_gnt1",   64'(gnt1),      64'd1);
      check("wr_we_c1",  64'(mem_we),    64'd1);
      check("wr_addr",   64'(mem_addr),  64'h20);
      check("wr_wdata",  64'(mem_wdata), 64'h12345678);
      req1 = 1'b0;
      cycle();
      check("wr_we_c2",  64'(mem_we),    64'd1);
      check("wr_addr2",  64'(mem_addr),  64'h20);
      cycle();
      check("wr_done1",  64'(done1),     64'd1);
      check("wr_done0",  64'(done0),     64'd0);
      check("wr_rdata1", 64'(rdata1),    64'hAAAA0000);
      cycle();

      // Continuous requests on both ports: strict alternation.
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 32'h44; addr1 = 32'h88; mem_rdata = 32'h0BADF00D;
      for (int i = 1; i <= 14; i++) begin
         cycle();
         if (gnt0) begin g_port.push_back(0); g_cyc.push_back(i); end
         if (gnt1) begin g_port.push_back(1); g_cyc.push_back(i); end
      end
      req0 = 1'b0; req1 = 1'b0;
      cycle(); cycle();
      check("rr_count", 64'(g_port.size()), 64'd4);
      for (int i = 0; i < g_port.size() && i < 4; i++) begin
         check("rr_order", 64'(g_port[i]), 64'(i % 2));
         if (i > 0) check("rr_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'd4);
      end

      // Port 0 drops its request mid-access: access still completes.
      req0 = 1'b1; addr0 = 32'h30; mem_rdata = 32'h11112222;
      cycle();
      check("drop_gnt0", 64'(gnt0), 64'd1);
      cycle();
      req0 = 1'b0;
      cycle();
      check("drop_done0",  64'(done0),  64'd1);
      check("drop_rdata0", 64'(rdata0), 64'h11112222);
      cycle();
      check("drop_no_gnt", 64'({gnt0, gnt1}), 64'd0);
      check("drop_idle",   64'(busy), 64'd0);
      cycle();

      // Reset during the second access cycle of a port 1 read.
      req1 = 1'b1; addr1 = 32'h40; mem_rdata = 32'h33334444;
      cycle();
      check("mr_gnt1", 64'(gnt1), 64'd1);
      req1 = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      check("mr_mem_en", 64'(mem_en), 64'd0);
      check("mr_busy",   64'(busy),   64'd0);
      check("mr_done",   64'({done0, done1}), 64'd0);
      check("mr_rdata",  64'({rdata0, rdata1}), 64'd0);
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
      cycle();
      check("mr_tie_gnt0", 64'(gnt0), 64'd1);
      check("mr_tie_gnt1", 64'(gnt1), 64'd0);
      req0 = 1'b0; req1 = 1'b0;
      cycle(); cycle(); cycle(); cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory used by the CPU MEM stage. It shares the memory between port 0 (CPU load/store path) and port 1 (loader/DMA path). Each granted command is held stable on the memory interface for a fixed access latency. Read data is returned with a one-cycle done pulse, and ties are resolved round-robin.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LATENCY, 2, memory access cycles; legal range 1..15
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous, active-high reset
- reqN_i  input  1  request from port N (N = 0, 1); held high until gntN_o
- weN_i  input  1  1 = write, 0 = read; sampled with the request
- addrN_i  input  ADDR_W  request address
- wdataN_i  input  DATA_W  write data
- gntN_o  output  1  one-cycle pulse; command accepted
- doneN_o  output  1  one-cycle pulse; access complete
- rdataN_o  output  DATA_W  read data; valid from the doneN_o cycle and held until the next read on port N completes
- mem_en_o  output  1  memory access active
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_rdata_i  input  DATA_W  memory read data; valid in the final ACCESS cycle
- busy_o  output  1  high whenever the state is not IDLE

## Operation
- The FSM has three states: IDLE, ACCESS, DONE.
- Every output is registered.
- Reset values:
  - state = IDLE
  - all gnt, done and mem_* outputs = 0
  - rdata0_o = rdata1_o = 0
  - busy_o = 0
  - last-grant pointer = 1, so port 0 wins the first tie
- IDLE, no request: the FSM stays in IDLE.
- IDLE, one request: that port is selected.
- IDLE, both requests: the port that is not the last-grant pointer is selected.
- On selection:
  - the FSM moves to ACCESS
  - gntN_o = 1 for one cycle
  - weN_i, addrN_i and wdataN_i are latched onto mem_we_o, mem_addr_o and mem_wdata_o
  - mem_en_o = 1
  - the last-grant pointer is set to N
  - the counter is loaded with LATENCY
- ACCESS:
  - the counter decrements every cycle
  - mem_* outputs are held stable for exactly LATENCY cycles
  - when the counter equals 1, the next edge moves to DONE, clears mem_en_o and mem_we_o, and asserts doneN_o for the owning port
  - on a read, that same edge captures mem_rdata_i into rdataN_o
  - on a write, rdataN_o is left unchanged
- DONE: lasts one cycle with doneN_o high, performs no arbitration, then returns to IDLE.
- The counter width is ceil(log2(LATENCY+1)). Because it is loaded with LATENCY, it never underflows.

## Timing
- Request sampled in IDLE at cycle 0:
  - gntN_o high in cycle 1
  - mem_en_o high in cycles 1..LATENCY
  - doneN_o high in cycle LATENCY+1
  - IDLE again in cycle LATENCY+2
- Throughput: one access every LATENCY+2 cycles per port pair.
- A request dropped before it is sampled in IDLE is never granted. There is no queueing.
- Request changes during ACCESS or DONE are ignored, and the in-flight access completes unchanged.
- A request still high in the cycle after gntN_o is treated as a new request when the FSM next reaches IDLE.
- Both ports requesting continuously are granted strictly alternately: 0, 1, 0, 1, …
- Reset mid-operation:
  - the next state is IDLE
  - mem_en_o drops on the following edge
  - no doneN_o is issued
  - rdata outputs return to 0
  - the pointer returns to 1
- Never permitted: two gnt pulses in one cycle, or mem_en_o high while in IDLE.

## Test plan
- Reset with both requests high and LATENCY=2: every output is 0 in the cycle after reset. After release, port 0 is granted first.
- Port 0 read, addr=0x10, memory returns 0xDEADBEEF: gnt0_o in cycle 1, mem_en_o in cycles 1–2, done0_o and rdata0_o=0xDEADBEEF in cycle 3, busy_o low in cycle 4.
- Port 1 write, addr=0x20, wdata=0x12345678:
  - mem_we_o=1 and mem_addr_o=0x20 stable for 2 cycles
  - done1_o in cycle 3
  - rdata1_o unchanged
  - port 0 outputs quiet throughout
- Both ports request continuously for 4 transactions: grant order 0, 1, 0, 1, with gnt pulses 4 cycles apart.
- Port 0 drops its request in cycle 2 of ACCESS: the access still completes and done0_o fires. The next cycle returns to IDLE with no grant.
- rst_i asserted in the second ACCESS cycle: state is IDLE and mem_en_o=0 on the next edge, no done pulse occurs, and the next tie grants port 0.
